// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall counter.
module pipe_stage_reg #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic load;
   assign load = ~out_valid | out_ready;
   generate
      if (SKID != 0) begin : g_skid
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;
         logic              in_xfer;
         // in_ready comes straight from a flop, so out_ready never reaches it
         assign in_ready = ~skid_valid;
         assign in_xfer  = in_valid & in_ready;
         always_ff @(posedge clock or negedge resetn)
            if (!resetn) begin
               out_valid  <= 1'b0;
               out_ctrl   <= '0;
               out_data   <= '0;
               skid_valid <= 1'b0;
               skid_ctrl  <= '0;
               skid_data  <= '0;
            end else if (flush) begin
               out_valid  <= 1'b0;
               out_ctrl   <= '0;
               skid_valid <= 1'b0;
            end else if (load) begin
               skid_valid <= 1'b0;
               out_valid  <= skid_valid | in_xfer;
               out_ctrl   <= skid_valid ? skid_ctrl : in_xfer ? in_ctrl : '0;
               if (skid_valid | in_xfer) out_data <= skid_valid ? skid_data : in_data;
            end else if (in_xfer) begin
               skid_valid <= 1'b1;
               skid_ctrl  <= in_ctrl;
               skid_data  <= in_data;
            end
      end else begin : g_reg
         assign in_ready = load;
         always_ff @(posedge clock or negedge resetn)
            if (!resetn) begin
               out_valid <= 1'b0;
               out_ctrl  <= '0;
               out_data  <= '0;
            end else if (flush) begin
               out_valid <= 1'b0;
               out_ctrl  <= '0;
            end else if (load) begin
               out_valid <= in_valid;
               out_ctrl  <= in_valid ? in_ctrl : '0;
               if (in_valid) out_data <= in_data;
            end
      end
   endgenerate
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) stall_cnt <= '0;
      else if (out_valid & ~out_ready & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the generalised successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field between stages using a valid/ready handshake. An optional skid buffer sustains full throughput under back-pressure. It also provides synchronous flush (bubble insertion) and a saturating stall counter for performance debug.

Parameters:
CTRL_W, 2, width of control field (e.g. wreg, m2reg); forced to zero whenever the stage holds a bubble
DATA_W, 69, width of data field (e.g. mo, alu, rn)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of the stall counter

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
out_valid  output  1  stage output holds a valid entry
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  registered control field; zero when out_valid=0
out_data  output  DATA_W  registered data field
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (resetn=0, asynchronous): out_valid=0, out_ctrl=0, out_data=0, skid entry cleared, stall_cnt=0. in_ready=1 during and after reset.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - in_valid must not depend combinationally on in_ready. Upstream must hold in_ctrl/in_data while in_valid=1 and in_ready=0.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 if the stage was empty or drained in cycle N. Throughput is 1 entry/cycle.
- SKID=1:
  - in_ready = ~skid_valid, registered; no combinational path from out_ready.
  - Main register loads when it is empty or an output transfer occurs. It takes the skid entry if skid_valid, else the input entry.
  - An input accepted while the main register is full and not draining goes to skid; skid_valid is set.
  - skid_valid clears when the skid entry moves to main.
  - Ordering is FIFO; never more than 2 entries.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Single register; no skid logic is synthesised.
- Bubble rule: whenever out_valid is 0 at a clock edge result, out_ctrl is 0. out_data retains its last value (don't-care for downstream).
- Flush (synchronous, highest priority):
  - At the edge: out_valid=0, out_ctrl=0, skid_valid=0.
  - Any input transfer in the flush cycle is consumed and discarded.
  - An output transfer in the flush cycle still completes.
  - in_ready=1 in the following cycle.
- Simultaneous transfers:
  - Input and output transfers in the same cycle with skid empty: main register replaced, no stall counted.
  - Output transfer with skid full plus input offered: in_ready was 0, so the input is not accepted.
- stall_cnt:
  - Increments by 1 each cycle where out_valid=1 and out_ready=0 and flush=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Reset mid-operation: all entries are lost immediately and the stage is empty. No partial entry survives.

Test Plan:
1. Streaming with out_ready=1, in_valid=1, in_data=1,2,3,4 each cycle -> out_data 1,2,3,4 one cycle later each cycle; in_ready stays 1; stall_cnt=0.
2. SKID=1: accept A=0x11 and B=0x22 on consecutive cycles while out_ready=0 -> out_data=0x11 held, in_ready=0 after B. Raise out_ready -> outputs 0x11, then 0x22, with no loss or duplication; stall_cnt equals the number of held cycles.
3. Flush with entries in main and skid (in_ctrl=2'b11) and in_valid=1 in the same cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the discarded input never appears.
4. Reset asserted mid-stream (asynchronously, between edges) -> out_valid, out_ctrl, and out_data go to 0 immediately without a clock edge; stall_cnt=0; first entry after release appears with 1-cycle latency.
5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
6. SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready follows ~out_valid|out_ready in the same cycle; data order is preserved.
